// File: rtl/sigmoid_pipe.sv
// Piecewise-quadratic sigmoid/tanh unit (tanh path built only with SIGMOID_PIPE_TANH_EN).
// Latency: 3 clk edges from input transfer to out_valid; 1 result/cycle when streaming.
// Backpressure: stall-all; every stage holds while out_valid & ~out_ready, in_ready drops.
module sigmoid_pipe #(
    parameter int IN_W    = 8,
    parameter int FRAC_IN = 4,
    parameter int OUT_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_count
);
    localparam int ONE_IN  = 1 << FRAC_IN;
    localparam int ONE_OUT = 1 << (2 * FRAC_IN);
    localparam int A_W     = IN_W + 1;
    localparam int D_W     = FRAC_IN + 1;
    localparam int SQ_W    = 2 * FRAC_IN + 1;

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en & ~reset;

    // ---------------- stage 1: magnitude, saturation, d ----------------
    logic           x_neg;
    logic [A_W-1:0] x_ext;
    logic [A_W-1:0] a;
    logic           sat_d;
    logic [D_W-1:0] d_d;

    logic           s1_vld;
    logic           s1_sign;
    logic           s1_sat;
    logic [D_W-1:0] s1_d;

`ifdef SIGMOID_PIPE_TANH_EN
    logic s1_mode;
    logic s2_mode;
`else
    logic unused_mode;
    assign unused_mode = in_mode;
`endif

    always_comb begin
        x_neg = in_x[IN_W-1];
        x_ext = {in_x[IN_W-1], in_x};
        // one extra bit keeps |most-negative| representable
        a     = x_neg ? (~x_ext + A_W'(1)) : x_ext;
        sat_d = (a >= A_W'(4 * ONE_IN));
        d_d   = sat_d ? '0 : D_W'(A_W'(ONE_IN) - (a >> 2));
`ifdef SIGMOID_PIPE_TANH_EN
        if (in_mode) begin
            sat_d = (a >= A_W'(2 * ONE_IN));
            d_d   = sat_d ? '0 : D_W'(A_W'(ONE_IN) - (a >> 1));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_sat  <= 1'b0;
            s1_d    <= '0;
        end else if (en) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_sign <= x_neg;
                s1_sat  <= sat_d;
                s1_d    <= d_d;
            end
        end
    end

    // ---------------- stage 2: square ----------------
    logic            s2_vld;
    logic            s2_sign;
    logic            s2_sat;
    logic [SQ_W-1:0] s2_sq;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_sat  <= 1'b0;
            s2_sq   <= '0;
        end else if (en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sign <= s1_sign;
                s2_sat  <= s1_sat;
                s2_sq   <= SQ_W'(s1_d * s1_d);
            end
        end
    end

`ifdef SIGMOID_PIPE_TANH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_mode <= 1'b0;
            s2_mode <= 1'b0;
        end else if (en) begin
            if (in_valid) s1_mode <= in_mode;
            if (s1_vld)   s2_mode <= s1_mode;
        end
    end
`endif

    // ---------------- stage 3: fold into output ----------------
    logic [SQ_W-1:0]  h;
    logic [SQ_W-1:0]  y_sig;
    logic [OUT_W-1:0] y_d;
`ifdef SIGMOID_PIPE_TANH_EN
    logic signed [SQ_W:0] m_s;
    logic signed [SQ_W:0] y_t;
`endif

    always_comb begin
        h     = s2_sq >> 1;
        y_sig = s2_sign ? h : (SQ_W'(ONE_OUT) - h);
        y_d   = OUT_W'(y_sig);
`ifdef SIGMOID_PIPE_TANH_EN
        m_s = {1'b0, SQ_W'(ONE_OUT) - s2_sq};
        y_t = s2_sign ? -m_s : m_s;
        if (s2_mode) y_d = OUT_W'(y_t);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_y   <= y_d;
                out_sat <= s2_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && !(&sat_count)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Directed bench for sigmoid_pipe at default parameters; tanh expectations follow SIGMOID_PIPE_TANH_EN.
module tb_sigmoid_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic        out_sat;
    logic [15:0] sat_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sigmoid_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat),
        .sat_count(sat_count)
    );

    function automatic logic [15:0] model(input logic [7:0] x, input logic mode, output logic sat);
        int xi, a, d, sq, y;
        logic tm;
        xi = int'($signed(x));
        a  = (xi < 0) ? -xi : xi;
`ifdef SIGMOID_PIPE_TANH_EN
        tm = mode;
`else
        tm = mode & 1'b0;
`endif
        if (tm) begin
            sat = (a >= 32);
            d   = sat ? 0 : 16 - (a >> 1);
            sq  = d * d;
            y   = 256 - sq;
            if (xi < 0) y = -y;
        end else begin
            sat = (a >= 64);
            d   = sat ? 0 : 16 - (a >> 2);
            sq  = d * d;
            y   = sq >> 1;
            if (xi >= 0) y = 256 - y;
        end
        model = y[15:0];
    endfunction

    // Offers one word to an idle pipe and waits for its result (out_ready held high).
    task automatic send_one(input logic [7:0] x, input logic m,
                            output logic [15:0] y, output logic s, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_x = x; in_mode = m; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        y = out_y;
        s = out_sat;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_y !== 16'h0) begin n_err++; $display("FAIL reset_out_y: got %h want 0000", out_y); end
        n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        n_vec++; if (sat_count !== 16'h0) begin n_err++; $display("FAIL reset_sat_count: got %h want 0000", sat_count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_held: got %b want 0", in_ready); end
        reset = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_release: got %b want 1", in_ready); end
    endtask

    task automatic test_sigmoid;
        logic [7:0]  xs [3] = '{8'h00, 8'h10, 8'hF0};
        logic [15:0] ys [3] = '{16'h0080, 16'h00B8, 16'h0048};
        logic [15:0] y;
        logic        s;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            send_one(xs[i], 1'b0, y, s, lat);
            n_vec++; if (lat !== 3) begin n_err++; $display("FAIL sig_latency x=%h: got %0d want 3", xs[i], lat); end
            n_vec++; if (y !== ys[i]) begin n_err++; $display("FAIL sig_y x=%h: got %h want %h", xs[i], y, ys[i]); end
            n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL sig_sat x=%h: got %b want 0", xs[i], s); end
        end
    endtask

    task automatic test_saturation;
        logic [7:0]  xs [2] = '{8'h40, 8'h80};
        logic [15:0] ys [2] = '{16'h0100, 16'h0000};
        logic [15:0] y;
        logic        s;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            send_one(xs[i], 1'b0, y, s, lat);
            n_vec++; if (y !== ys[i]) begin n_err++; $display("FAIL sat_y x=%h: got %h want %h", xs[i], y, ys[i]); end
            n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL sat_flag x=%h: got %b want 1", xs[i], s); end
        end
        @(negedge clk);
        n_vec++; if (sat_count !== 16'd2) begin n_err++; $display("FAIL sat_count: got %0d want 2", sat_count); end
    endtask

    task automatic test_tanh;
        logic [15:0] y;
        logic        s;
        int          lat;
`ifdef SIGMOID_PIPE_TANH_EN
        logic [7:0]  xs [4] = '{8'h10, 8'hF0, 8'h20, 8'h00};
        logic [15:0] ys [4] = '{16'h00C0, 16'hFF40, 16'h0100, 16'h0000};
        logic        ss [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send_one(xs[i], 1'b1, y, s, lat);
            n_vec++; if (y !== ys[i]) begin n_err++; $display("FAIL tanh_y x=%h: got %h want %h", xs[i], y, ys[i]); end
            n_vec++; if (s !== ss[i]) begin n_err++; $display("FAIL tanh_sat x=%h: got %b want %b", xs[i], s, ss[i]); end
        end
`else
        send_one(8'h10, 1'b1, y, s, lat);
        n_vec++; if (y !== 16'h00B8) begin n_err++; $display("FAIL mode_ignored_y: got %h want 00b8", y); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL mode_ignored_sat: got %b want 0", s); end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [7:0]  xs [4] = '{8'h00, 8'h08, 8'h18, 8'h28};
        logic [15:0] ys [3] = '{16'h0080, 16'h009E, 16'h00CE};
        int acc = 0;
        int k = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = xs[acc]; in_mode = 1'b0; out_ready = 1'b0;
            #1;
            if (in_ready) acc++;
        end
        n_vec++; if (acc !== 3) begin n_err++; $display("FAIL bp_accepted: got %0d want 3", acc); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        n_vec++; if (out_y !== 16'h0080) begin n_err++; $display("FAIL bp_held_y: got %h want 0080", out_y); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (k < 3) begin
                    n_vec++;
                    if (out_y !== ys[k]) begin n_err++; $display("FAIL bp_drain[%0d]: got %h want %h", k, out_y, ys[k]); end
                end
                k++;
            end
        end
        n_vec++; if (k !== 3) begin n_err++; $display("FAIL bp_drain_count: got %0d want 3", k); end
    endtask

    task automatic test_back_to_back(input bit rnd);
        logic [15:0] exp_y [$];
        logic        exp_s [$];
        logic [15:0] ey;
        logic        es;
        logic [7:0]  xv;
        logic        mv;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < 32 && cyc < 400) begin
            @(negedge clk);
            xv = 8'(sent * 37 + 3);
            mv = sent[0];
            in_valid  = (sent < 32);
            in_x      = xv;
            in_mode   = mv;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_y.size() == 0) begin
                    n_err++; $display("FAIL stream_extra rnd=%0d: got %h want none", rnd, out_y);
                end else begin
                    ey = exp_y.pop_front();
                    es = exp_s.pop_front();
                    if (out_y !== ey || out_sat !== es) begin
                        n_err++;
                        $display("FAIL stream[%0d] rnd=%0d: got %h/%b want %h/%b", got, rnd, out_y, out_sat, ey, es);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ey = model(xv, mv, es);
                exp_y.push_back(ey);
                exp_s.push_back(es);
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++; if (got !== 32) begin n_err++; $display("FAIL stream_count rnd=%0d: got %0d want 32", rnd, got); end
        if (!rnd) begin
            n_vec++; if (cyc !== 35) begin n_err++; $display("FAIL stream_throughput: got %0d cycles want 35", cyc); end
        end
    endtask

    task automatic test_reset_midflight;
        logic [7:0] xs [4] = '{8'h40, 8'h80, 8'h40, 8'h40};
        int acc = 0;
        int seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = xs[acc]; in_mode = 1'b0; out_ready = 1'b0;
            #1;
            if (in_ready) acc++;
        end
        n_vec++; if (acc !== 3) begin n_err++; $display("FAIL mid_fill: got %0d want 3", acc); end
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_vec++; if (sat_count !== 16'h0) begin n_err++; $display("FAIL mid_sat_count: got %h want 0000", sat_count); end
        n_vec++; if (out_y !== 16'h0) begin n_err++; $display("FAIL mid_out_y: got %h want 0000", out_y); end
        reset = 1'b0; out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready_release: got %b want 1", in_ready); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL mid_flushed_words: got %0d want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_sigmoid;
        test_saturation;
        test_tanh;
        test_backpressure;
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_midflight;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
